// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - shared op encodings, FSM states and constants for alu_multicycle
package alu_multicycle_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_MLA  = 3'b100;
    localparam logic [2:0] ALU_SDIV = 3'b101;
    localparam logic [2:0] ALU_UDIV = 3'b110;

    // Every bit of the divide-by-zero quotient takes this value (all ones).
    localparam logic DIV_ZERO_QUOTIENT_BIT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_multicycle_div_iter.sv
// rtl/alu_multicycle_div_iter.sv - restoring unsigned divide datapath, one iteration per step
//
// Ports:
//   clk, reset         clock and asynchronous active-low reset
//   load               capture dividend/divisor and clear the partial remainder
//   step               perform one restoring iteration
//   dividend, divisor  unsigned operands (magnitudes for a signed divide)
//   quotient           registered quotient
//   quotient_next      quotient after the iteration in progress this cycle
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] quotient_next
);

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_next;
    logic             trial_neg;

    // The quotient register doubles as the dividend shift register: its MSB
    // shifts into the remainder while the new quotient bit enters at the LSB.
    always_comb begin
        trial     = {rem, quotient[WIDTH-1]} - {2'b00, dvsr};
        trial_neg = trial[WIDTH+1];
        if (trial_neg) begin
            rem_next      = {rem[WIDTH-1:0], quotient[WIDTH-1]};
            quotient_next = {quotient[WIDTH-2:0], 1'b0};
        end else begin
            rem_next      = trial[WIDTH:0];
            quotient_next = {quotient[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
        end else if (load) begin
            rem      <= '0;
            dvsr     <= divisor;
            quotient <= dividend;
        end else if (step) begin
            rem      <= rem_next;
            quotient <= quotient_next;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: 1-cycle ADD/SUB/AND/ORR, iterative MLA, SDIV, UDIV
//
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   start           request, sampled only while not busy
//   op              operation select (see package encodings; 111 reserved -> 0)
//   a, b, ra        SrcA, SrcB and MLA accumulate operand
//   busy            high during MUL, DIV and FIX cycles
//   done            one-cycle pulse when result becomes valid
//   result          registered result, held until the next accepted start
//   div_by_zero     valid with done; high if a divide had b = 0
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] ra,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic             accept;
    logic             last_iter;
    logic             is_div;
    logic             b_zero;

    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic [WIDTH-1:0] acc, mcand, mplier, acc_next;

    logic             div_load;
    logic             div_step;
    logic [WIDTH-1:0] div_dividend, div_divisor;
    logic [WIDTH-1:0] quotient, quotient_next;

    assign busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign done      = (state == S_DONE);
    assign last_iter = (cnt == LAST);
    assign is_div    = (op == ALU_SDIV) || (op == ALU_UDIV);
    assign b_zero    = (b == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (start) begin
                    accept = 1'b1;
                    if (op == ALU_MLA) begin
                        state_next = S_MUL;
                    end else if (is_div && !b_zero) begin
                        state_next = S_DIV;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (last_iter) begin
                    state_next = (op_q == ALU_SDIV) ? S_FIX : S_DONE;
                end
            end
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shift-add multiplier: one multiplier bit per cycle, accumulator seeded with ra.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // SDIV divides magnitudes; the sign is reapplied in FIX. |MIN| is MIN as an
    // unsigned value, which is the correct magnitude.
    assign div_load     = accept && is_div && !b_zero;
    assign div_step     = (state == S_DIV);
    assign div_dividend = (op == ALU_SDIV && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign div_divisor  = (op == ALU_SDIV && b[WIDTH-1]) ? (~b + 1'b1) : b;

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk           (clk),
        .reset         (reset),
        .load          (div_load),
        .step          (div_step),
        .dividend      (div_dividend),
        .divisor       (div_divisor),
        .quotient      (quotient),
        .quotient_next (quotient_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= ALU_ADD;
            cnt         <= '0;
            neg_q       <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q        <= op;
            cnt         <= '0;
            neg_q       <= (op == ALU_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc         <= ra;
            mcand       <= a;
            mplier      <= b;
            div_by_zero <= 1'b0;
            case (op)
                ALU_ADD: result <= a + b;
                ALU_SUB: result <= a - b;
                ALU_AND: result <= a & b;
                ALU_ORR: result <= a | b;
                ALU_MLA: result <= result;
                ALU_SDIV, ALU_UDIV: begin
                    if (b_zero) begin
                        result      <= {WIDTH{DIV_ZERO_QUOTIENT_BIT}};
                        div_by_zero <= 1'b1;
                    end
                end
                default: result <= '0;
            endcase
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= acc_next;
                    end
                end
                S_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (last_iter && op_q == ALU_UDIV) begin
                        result <= quotient_next;
                    end
                end
                S_FIX: begin
                    result <= neg_q ? (~quotient + 1'b1) : quotient;
                end
                default: ;
            endcase
        end
    end

endmodule
